// File: rtl/jpeg_bitpacker.sv
// JPEG entropy-coded segment bit packer: MSB-first code accumulation, byte output, flush padding with 1s.
// Define JPEG_BYTE_STUFF_EN to insert a 0x00 byte after every emitted 0xFF.
module jpeg_bitpacker #(
  parameter int ACC_W  = 32,
  parameter int CODE_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [CODE_W-1:0] code_bits,
  input  logic [4:0]        code_length,
  input  logic              flush,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [7:0]        byte_data,
  output logic              flush_done,
  output logic [31:0]       byte_count
);

  localparam int CNT_W = $clog2(ACC_W + 1);
`ifdef JPEG_BYTE_STUFF_EN
  localparam bit STUFF_EN = 1'b1;
`else
  localparam bit STUFF_EN = 1'b0;
`endif

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stuff_q, stuff_d;
  logic              byte_valid_q, byte_valid_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic [31:0]       byte_count_q, byte_count_d;

  logic [CNT_W-1:0]  len;
  logic [CODE_W-1:0] code_masked;
  logic              push, out_load, pop;
  logic [ACC_W-1:0]  acc_base;
  logic [CNT_W-1:0]  cnt_base;
  logic [7:0]        top_byte;

  assign code_ready = (state_q == RUN) && (cnt_q <= CNT_W'(ACC_W - CODE_W)) && reset_n;

  always_comb begin
    if (int'(code_length) > CODE_W) len = CNT_W'(CODE_W);
    else                            len = CNT_W'(code_length);
    code_masked = code_bits & ~({CODE_W{1'b1}} << len);
  end

  always_comb begin
    state_d      = state_q;
    stuff_d      = stuff_q;
    byte_valid_d = byte_valid_q;
    byte_data_d  = byte_data_q;
    byte_count_d = byte_count_q + 32'(byte_valid_q && byte_ready);
    flush_done   = 1'b0;
    top_byte     = acc_q[ACC_W-1 -: 8];
    push         = code_valid && code_ready;
    out_load     = !byte_valid_q || byte_ready;
    pop          = out_load && !stuff_q && (cnt_q >= CNT_W'(8));

    if (out_load) begin
      if (stuff_q) begin
        byte_valid_d = 1'b1;
        byte_data_d  = '0;
        stuff_d      = 1'b0;
      end else if (pop) begin
        byte_valid_d = 1'b1;
        byte_data_d  = top_byte;
        stuff_d      = STUFF_EN && (top_byte == 8'hFF);
      end else begin
        byte_valid_d = 1'b0;
      end
    end

    // Pop is applied first so the incoming code lands directly below the surviving bits.
    acc_base = pop ? (acc_q << 8) : acc_q;
    cnt_base = pop ? (cnt_q - CNT_W'(8)) : cnt_q;
    acc_d    = acc_base;
    cnt_d    = cnt_base;
    if (push) begin
      acc_d = acc_base | (ACC_W'(code_masked) << (CNT_W'(ACC_W) - cnt_base - len));
      cnt_d = cnt_base + len;
    end

    unique case (state_q)
      RUN: begin
        if (flush) state_d = FLUSH;
      end
      FLUSH: begin
        // Bits below cnt are always zero, so OR-ing the pad mask fills only the invalid tail.
        if ((cnt_q != '0) && (cnt_q < CNT_W'(8)) && !stuff_q) begin
          acc_d[ACC_W-1 -: 8] = top_byte | (8'hFF >> cnt_q);
          cnt_d               = CNT_W'(8);
        end
        if ((cnt_q == '0) && !stuff_q && !byte_valid_q) state_d = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      acc_q        <= '0;
      cnt_q        <= '0;
      stuff_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      stuff_q      <= stuff_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_jpeg_bitpacker.sv
// Bench for jpeg_bitpacker: table vectors, hand-written corner sequences, random codes vs a bit-queue model.
module tb_jpeg_bitpacker;

`ifdef JPEG_BYTE_STUFF_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        code_valid = 1'b0;
  logic        flush = 1'b0;
  logic        byte_ready = 1'b0;
  logic [15:0] code_bits = '0;
  logic [4:0]  code_length = '0;
  logic        code_ready, byte_valid, flush_done;
  logic [7:0]  byte_data;
  logic [31:0] byte_count;

  jpeg_bitpacker #(.ACC_W(32), .CODE_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .code_valid(code_valid), .code_ready(code_ready),
    .code_bits(code_bits), .code_length(code_length),
    .flush(flush),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .flush_done(flush_done), .byte_count(byte_count)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  int unsigned checks = 0, errors = 0;
  int unsigned hs_total = 0, done_cnt = 0, rdy_viol = 0;
  bit          rnd_ready = 1'b0, in_flush = 1'b0;
  logic [7:0]  got[$];
  logic [7:0]  expq[$];
  bit          bitq[$];

  typedef struct {
    int unsigned     nc;
    logic [1:0][15:0] bits;
    logic [1:0][4:0]  len;
    bit              fl;
    int unsigned     ne;
    logic [2:0][7:0] ex;
  } vec_t;

  localparam int NV = 6;
  vec_t  vt[NV];
  string vn[NV];

  function automatic vec_t mk(input int unsigned nc, input logic [15:0] b0, input logic [4:0] l0,
                              input logic [15:0] b1, input logic [4:0] l1, input bit fl,
                              input int unsigned ne, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2);
    vec_t r;
    r.nc = nc; r.fl = fl; r.ne = ne;
    r.bits[0] = b0; r.bits[1] = b1;
    r.len[0] = l0;  r.len[1] = l1;
    r.ex[0] = e0; r.ex[1] = e1; r.ex[2] = e2;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=wait-expired required=event-in-time", name);
  endtask

  task automatic samp();
    @(negedge clock);
    if (reset_n && byte_valid && byte_ready) begin
      got.push_back(byte_data);
      hs_total++;
    end
    if (flush_done) done_cnt++;
    if (in_flush && code_ready) rdy_viol++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rnd_ready) byte_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin samp(); tick(); end
  endtask

  task automatic send_code(input logic [15:0] b, input logic [4:0] l);
    int unsigned n = 0;
    code_valid = 1'b1; code_bits = b; code_length = l;
    forever begin
      samp();
      if (code_ready) break;
      n++;
      if (n > 500) begin timeout("send_code"); break; end
      tick();
    end
    tick();
    code_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int unsigned need, input string p);
    int unsigned n = 0;
    forever begin
      samp();
      if (got.size() >= need) break;
      n++;
      if (n > 2000) begin timeout({p, "_bytes"}); break; end
      tick();
    end
    tick();
  endtask

  task automatic wait_done(input int unsigned d0, input string p);
    int unsigned n = 0;
    forever begin
      samp();
      if (done_cnt > d0) break;
      n++;
      if (n > 3000) begin timeout({p, "_flush_done"}); break; end
      tick();
    end
    tick();
  endtask

  task automatic flush_wait(input string p);
    int unsigned d0 = done_cnt;
    flush = 1'b1;
    samp();
    tick();
    flush = 1'b0;
    in_flush = 1'b1;
    wait_done(d0, p);
    in_flush = 1'b0;
  endtask

  task automatic cmp_bytes(input string p, input logic [7:0] e[$]);
    chk({p, "_nbytes"}, got.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s_byte%0d", p, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF, 32'(e[i]));
  endtask

  task automatic chk_count(input string p);
    samp();
    chk({p, "_byte_count"}, byte_count, hs_total - ((byte_valid && byte_ready) ? 1 : 0));
    tick();
  endtask

  task automatic model_code(input logic [15:0] b, input logic [4:0] l);
    int n = (l > 16) ? 16 : int'(l);
    for (int i = n - 1; i >= 0; i--) bitq.push_back(b[i]);
  endtask

  task automatic model_flush();
    logic [7:0] v;
    while (bitq.size() % 8 != 0) bitq.push_back(1'b1);
    while (bitq.size() >= 8) begin
      v = '0;
      for (int i = 0; i < 8; i++) v = {v[6:0], bitq.pop_front()};
      expq.push_back(v);
      if (STUFF && v == 8'hFF) expq.push_back(8'h00);
    end
  endtask

  initial begin
    logic [7:0] e[$];
    int unsigned d0;

    vt[0] = mk(2, 16'hFFFD, 5'd3, 16'hFFFF, 5'd5, 1'b0, 1, 8'hBF, 8'h00, 8'h00); vn[0] = "pack_bf";
    if (STUFF) vt[1] = mk(2, 16'h00FF, 5'd8, 16'h0012, 5'd8, 1'b0, 3, 8'hFF, 8'h00, 8'h12);
    else       vt[1] = mk(2, 16'h00FF, 5'd8, 16'h0012, 5'd8, 1'b0, 2, 8'hFF, 8'h12, 8'h00);
    vn[1] = "ff_stuff";
    vt[2] = mk(1, 16'h1232, 5'd3, 16'h0000, 5'd0, 1'b1, 1, 8'h5F, 8'h00, 8'h00); vn[2] = "pad_5f";
    if (STUFF) vt[3] = mk(1, 16'h000F, 5'd4, 16'h0000, 5'd0, 1'b1, 2, 8'hFF, 8'h00, 8'h00);
    else       vt[3] = mk(1, 16'h000F, 5'd4, 16'h0000, 5'd0, 1'b1, 1, 8'hFF, 8'h00, 8'h00);
    vn[3] = "pad_ff";
    vt[4] = mk(2, 16'hFFFF, 5'd0, 16'hF0A5, 5'd8, 1'b0, 1, 8'hA5, 8'h00, 8'h00); vn[4] = "len0";
    vt[5] = mk(1, 16'h8001, 5'd20, 16'h0000, 5'd0, 1'b0, 2, 8'h80, 8'h01, 8'h00); vn[5] = "len_clamp";

    // Reset state
    samp();
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_data", byte_data, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_code_ready", code_ready, 0);
    tick(); tick();
    reset_n = 1'b1; byte_ready = 1'b1;
    samp();
    chk("ready_after_release", code_ready, 1);
    tick();

    for (int v = 0; v < NV; v++) begin
      got.delete(); e.delete();
      d0 = done_cnt; rdy_viol = 0;
      for (int c = 0; c < int'(vt[v].nc); c++) send_code(vt[v].bits[c], vt[v].len[c]);
      if (vt[v].fl) flush_wait(vn[v]);
      else          wait_bytes(vt[v].ne, vn[v]);
      idle(4);
      for (int i = 0; i < int'(vt[v].ne); i++) e.push_back(vt[v].ex[i]);
      cmp_bytes(vn[v], e);
      chk({vn[v], "_flush_pulses"}, done_cnt - d0, vt[v].fl ? 1 : 0);
      if (vt[v].fl) chk({vn[v], "_ready_low_flush"}, rdy_viol, 0);
      chk_count(vn[v]);
    end

    // Code and flush in the same cycle: the code is included in the flush
    got.delete(); e.delete(); d0 = done_cnt; rdy_viol = 0;
    code_valid = 1'b1; code_bits = 16'h0001; code_length = 5'd1; flush = 1'b1;
    samp();
    chk("same_cycle_ready", code_ready, 1);
    tick();
    code_valid = 1'b0; flush = 1'b0; in_flush = 1'b1;
    wait_done(d0, "same_cycle");
    in_flush = 1'b0;
    idle(2);
    e.push_back(8'hFF);
    if (STUFF) e.push_back(8'h00);
    cmp_bytes("same_cycle", e);
    chk("same_cycle_pulses", done_cnt - d0, 1);
    chk("same_cycle_ready_low", rdy_viol, 0);

    // Empty flush: flush_done exactly in the second cycle after the request edge
    got.delete();
    flush = 1'b1;
    samp(); tick();
    flush = 1'b0;
    samp(); chk("empty_flush_k", flush_done, 0); tick();
    samp(); chk("empty_flush_k1", flush_done, 1); tick();
    samp(); chk("empty_flush_k2", flush_done, 0); chk("empty_flush_ready", code_ready, 1); tick();
    chk("empty_flush_nbytes", got.size(), 0);

    // Backpressure: accumulator fills, output byte held, nothing lost
    got.delete(); e.delete();
    byte_ready = 1'b0;
    send_code(16'hABCD, 5'd16);
    send_code(16'hABCD, 5'd16);
    code_valid = 1'b1; code_bits = 16'hABCD; code_length = 5'd16;
    for (int i = 0; i < 6; i++) begin
      samp();
      chk($sformatf("bp_ready_low%0d", i), code_ready, 0);
      chk($sformatf("bp_valid%0d", i), byte_valid, 1);
      chk($sformatf("bp_data_hold%0d", i), byte_data, 8'hAB);
      tick();
    end
    byte_ready = 1'b1;
    send_code(16'hABCD, 5'd16);
    send_code(16'hABCD, 5'd16);
    wait_bytes(8, "backpressure");
    idle(4);
    repeat (4) begin e.push_back(8'hAB); e.push_back(8'hCD); end
    cmp_bytes("backpressure", e);
    chk_count("backpressure");

    // Reset mid-operation with 13 bits buffered and a byte pending
    got.delete(); e.delete();
    byte_ready = 1'b0;
    send_code(16'hABCD, 5'd16);
    send_code(16'h001F, 5'd5);
    samp();
    chk("pre_reset_valid", byte_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_reset_valid", byte_valid, 0);
    chk("mid_reset_count", byte_count, 0);
    chk("mid_reset_ready", code_ready, 0);
    hs_total = 0;
    got.delete();
    tick(); tick();
    reset_n = 1'b1; byte_ready = 1'b1;
    samp();
    chk("post_reset_ready", code_ready, 1);
    tick();
    send_code(16'h003C, 5'd8);
    wait_bytes(1, "post_reset");
    idle(4);
    e.push_back(8'h3C);
    cmp_bytes("post_reset", e);
    chk("post_reset_count", byte_count, 1);

    // Random codes and random backpressure against the bit-queue model
    rnd_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      logic [15:0] b;
      logic [4:0]  l;
      got.delete(); expq.delete(); bitq.delete();
      d0 = done_cnt; rdy_viol = 0;
      for (int n = 0; n < 40; n++) begin
        idle($urandom_range(0, 2));
        b = 16'($urandom);
        l = 5'($urandom_range(0, 20));
        model_code(b, l);
        send_code(b, l);
      end
      flush_wait($sformatf("rnd%0d", r));
      idle(2);
      model_flush();
      cmp_bytes($sformatf("rnd%0d", r), expq);
      chk($sformatf("rnd%0d_pulses", r), done_cnt - d0, 1);
      chk($sformatf("rnd%0d_ready_low_flush", r), rdy_viol, 0);
      chk_count($sformatf("rnd%0d", r));
    end
    rnd_ready = 1'b0;
    byte_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jpeg_bitpacker.md
# jpeg_bitpacker

Serialises the variable-length Huffman codes produced by the encoder's Huffman controller (DC code + length, AC code + length) into a byte stream for the JPEG entropy-coded segment. Packs codes MSB-first into an accumulator, emits whole bytes under ready/valid backpressure, inserts JPEG byte stuffing (0x00 after every 0xFF), and on flush pads the final partial byte with 1s. Sits directly downstream of the Huffman encode controller and feeds the byte FIFO / file writer.

## Interface
- ACC_W, 32, accumulator width in bits; must be >= CODE_W + 8
- CODE_W, 16, maximum code length accepted per beat
- clock  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- code_valid  input  1  code_bits/code_length valid this cycle
- code_ready  output  1  block can accept a code this cycle
- code_bits  input  CODE_W  code, LSB-justified; only low code_length bits used
- code_length  input  5  number of valid bits, 0..16; values 17..31 treated as 16
- flush  input  1  one-cycle request to pad and drain at end of scan
- byte_valid  output  1  byte_data holds an output byte
- byte_ready  input  1  downstream accepts byte this cycle
- byte_data  output  8  output byte
- flush_done  output  1  one-cycle pulse: flush complete, accumulator empty
- byte_count  output  32  bytes handed off (valid && ready), stuffing bytes included

## Operation
- State: acc[ACC_W-1:0], cnt (0..ACC_W valid bits, left-aligned at acc MSB), stuff_pending, FSM {RUN, FLUSH, DONE}.
- code_ready = (state==RUN) && (cnt <= ACC_W-CODE_W) && reset_n; combinational from registered state only.
- Push: on code_valid && code_ready, low code_length bits appended below the current cnt valid bits, MSB of code first; cnt += code_length. Length 0 accepted, no effect.
- Pop: output register loads when (!byte_valid || byte_ready). Priority: stuff_pending -> load 0x00, clear stuff_pending; else if cnt >= 8 -> load acc top 8 bits, shift acc left 8, cnt -= 8; set stuff_pending if byte loaded is 0xFF.
- Push and pop in same cycle: cnt_next = cnt + code_length - 8; both applied.
- flush sampled in RUN only (ignored in FLUSH/DONE). If code_valid && code_ready and flush in same cycle: code accepted first, included in the flush.
- FLUSH: code_ready = 0. When 0 < cnt < 8 and no stuff pending, valid bits padded with 1s to a full byte (cnt set to 8), then popped normally (0xFF pad result triggers stuffing). Exit to DONE when cnt==0, !stuff_pending, !byte_valid.
- DONE: flush_done high one cycle; next state RUN.
- byte_count increments on every byte_valid && byte_ready handshake.

## Timing
- Reset (async assert): byte_valid=0, byte_data=0x00, flush_done=0, byte_count=0, code_ready=0, cnt=0, acc=0, stuff_pending=0, state=RUN. code_ready rises in the first cycle after release.
- Latency: code accepted at edge k that brings cnt >= 8 -> byte_valid high after edge k+1.
- Throughput: one byte per cycle with byte_ready held high; code acceptance throttled only by cnt > ACC_W-CODE_W.
- byte_data/byte_valid stable while byte_valid && !byte_ready.
- Empty flush (cnt=0, output idle) sampled at edge k -> FLUSH at k, DONE after k+1, flush_done high for cycle after edge k+1.
- Reset asserted mid-operation discards accumulator and any pending byte immediately; no partial byte emitted after release.

## Configuration
- JPEG_BYTE_STUFF_EN defined: 0x00 inserted after every emitted 0xFF (including pad-generated 0xFF); counted in byte_count.
- Undefined: stuff_pending logic removed; 0xFF emitted as-is; otherwise identical.

## Test plan
- Codes 0b101/len3 then 0b11111/len5, byte_ready=1 -> single byte 0xBF, byte_count=1.
- Code 0xFF/len8 then 0x12/len8 -> bytes 0xFF, 0x00, 0x12 with JPEG_BYTE_STUFF_EN; 0xFF, 0x12 without.
- Code 0b010/len3 then flush -> byte 0x5F, then flush_done one-cycle pulse, code_ready low throughout FLUSH; code 0b1111/len4 then flush -> 0xFF, 0x00, flush_done.
- Four codes 0xABCD/len16 with byte_ready low 6 cycles -> code_ready drops when cnt > 16, byte_data held 0xAB, after release bytes AB CD AB CD AB CD AB CD, none lost or duplicated.
- Code valid and flush same cycle (0b1/len1, acc empty) -> byte 0xFF, stuffing 0x00, then flush_done; empty flush -> flush_done two cycles after request, no bytes.
- reset_n low with cnt=13 and byte_valid=1 -> byte_valid=0, byte_count=0 at once; after release 0x3C/len8 -> first byte 0x3C.
